// File: rtl/risc_dmem_arbiter.sv
// 16 x 8 data memory shared by a CPU port and a loader/debug port.
// One access per cycle; contention is resolved by a toggling priority pointer.
module risc_dmem_arbiter #(
  parameter bit CPU_FIRST = 1'b1,
  parameter bit MEM_CLEAR = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_enbl,
  input  logic       cpu_rdwr,
  input  logic [3:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  output logic       cpu_stall,
  input  logic       ld_req,
  input  logic       ld_rdwr,
  input  logic [3:0] ld_addr,
  input  logic [7:0] ld_wdata,
  output logic       ld_gnt,
  output logic [7:0] ld_rdata,
  output logic       ld_rvld,
  output logic [7:0] stall_cnt
);

  logic [7:0] r_mem [16];
  logic       r_prio;
  logic [7:0] r_cpu_rdata;
  logic [7:0] r_ld_rdata;
  logic       r_ld_rvld;
  logic [7:0] r_stall_cnt;

  logic       w_cpu_win;
  logic       w_ld_win;
  logic       w_wr_en;
  logic [3:0] w_addr;
  logic [7:0] w_wdata;

  // A requester wins alone, or when both ask and the pointer favours it.
  always_comb begin
    w_cpu_win = rst_n & cpu_enbl & (~ld_req | r_prio);
    w_ld_win  = rst_n & ld_req & (~cpu_enbl | ~r_prio);
    w_addr    = w_ld_win ? ld_addr : cpu_addr;
    w_wdata   = w_ld_win ? ld_wdata : cpu_wdata;
    w_wr_en   = (w_cpu_win & ~cpu_rdwr) | (w_ld_win & ~ld_rdwr);
  end

  assign cpu_stall = cpu_enbl & w_ld_win;
  assign ld_gnt    = w_ld_win;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_word
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          if (MEM_CLEAR) r_mem[gi] <= 8'h00;
        end else if (w_wr_en && (w_addr == 4'(gi))) begin
          r_mem[gi] <= w_wdata;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prio      <= CPU_FIRST;
      r_cpu_rdata <= 8'h00;
      r_ld_rdata  <= 8'h00;
      r_ld_rvld   <= 1'b0;
      r_stall_cnt <= 8'h00;
    end else begin
      // After contention the loser gets priority next time.
      if (cpu_enbl && ld_req) r_prio <= ~w_cpu_win;
      if (w_cpu_win && cpu_rdwr) r_cpu_rdata <= r_mem[cpu_addr];
      if (w_ld_win && ld_rdwr) r_ld_rdata <= r_mem[ld_addr];
      r_ld_rvld <= w_ld_win & ld_rdwr;
      if (cpu_stall && (r_stall_cnt != 8'hFF)) r_stall_cnt <= r_stall_cnt + 8'd1;
    end
  end

  assign cpu_rdata = r_cpu_rdata;
  assign ld_rdata  = r_ld_rdata;
  assign ld_rvld   = r_ld_rvld;
  assign stall_cnt = r_stall_cnt;

endmodule
